fetch_unit: RTL and testbench
=============================

# fetch_unit

- **Role:** instruction-fetch stage of the 8-bit micro. It sits directly upstream of the controller.
- **Owns:** the program counter (PC) and the instruction register (IR).
- **Fetch:** fetches instructions from instruction memory over a req/valid handshake.
- **Outputs to controller:** Opcode and the 4-bit operand.
- **Inputs from controller:** LoadIR, IncPC, SelPC and LoadPC, which drive fetch and PC update.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset.
- CLK  in  1  system clock; all state changes on the rising edge.
- CLB  in  1  reset, asynchronous, active-low.
- LoadIR  in  1  request to fetch the instruction at the current PC into IR.
- IncPC  in  1  PC <= PC + 1.
- LoadPC  in  1  load PC with the jump target.
- SelPC  in  1  jump target select: 1 = RegData, 0 = {4'b0000, Operand}.
- RegData  in  8  register-file value, used for register-indirect jumps.
- mem_addr  out  8  instruction memory address.
- mem_req  out  1  fetch request (level).
- mem_rdata  in  8  instruction memory read data.
- mem_valid  in  1  read data valid.
- Opcode  out  4  IR[7:4].
- Operand  out  4  IR[3:0].
- PC  out  8  current program counter.
- Busy  out  1  fetch in progress; the controller must hold its state while this is 1.

## Operation
- **FSM states:** IDLE and WAIT.
- **IDLE:**
  - LoadIR=1 at an edge: latch mem_addr <= PC (the pre-update PC), set mem_req <= 1, go to WAIT.
- **WAIT:**
  - mem_req=1 and mem_addr is held stable.
  - mem_valid=1 at an edge: IR <= mem_rdata, mem_req <= 0, go to IDLE.
  - mem_valid=0: remain in WAIT indefinitely; there is no timeout.
- **Other handshake rules:**
  - mem_valid is ignored in IDLE.
  - LoadIR is ignored in WAIT.
- **PC update** (evaluated every edge, independent of FSM state):
  - LoadPC=1: PC <= SelPC ? RegData : {4'b0000, Operand}.
  - Else IncPC=1: PC <= PC + 1, modulo 256 (8'hFF wraps to 8'h00).
  - Else PC holds.
  - LoadPC takes priority over IncPC when both are asserted.
- **LoadIR with a PC update in the same cycle:** the fetch uses the old PC, and the PC update still occurs.
- **Operand during a jump:** Operand is the IR content before any in-flight fetch completes. A jump therefore uses the current instruction's operand.
- **Busy** = (state == WAIT), decoded directly from the state register with no extra logic.
- **Reset values** (asynchronous on CLB=0): PC=RESET_PC, IR=8'h00 (Opcode 0000 = NOP), mem_req=0, mem_addr=8'h00, Busy=0, state=IDLE.
- **Reset during WAIT:** the fetch is aborted and mem_req drops asynchronously. Any mem_valid arriving afterwards is ignored.

## Timing
- LoadIR sampled at edge n → mem_req=1 and mem_addr=PC(n) from just after edge n.
- Earliest completion is mem_valid=1 at edge n+1. IR and Opcode/Operand are then updated just after edge n+1, so the minimum fetch latency is 1 cycle.
- A memory with k wait cycles completes at edge n+1+k.
- Busy is 1 from just after edge n until just after the completing edge.
- All outputs are registered. There is no combinational path from any input to any output.
- The PC update has 1-cycle latency and applies in both IDLE and WAIT.
- Back-to-back fetch: LoadIR may be asserted in the cycle immediately after Busy falls.

## Structure
- **Shared package** (micro_pkg), holding:
  - the opcode constants shared with the controller: NOP=4'h0, ADD=4'h1, SUB=4'h2, NOR=4'h3, MOVRS=4'h4, MOVRD=4'h5, JZR=4'h6, JZI=4'h7, JCR=4'h8, SHL=4'hB, SHR=4'hC, LDI=4'hD, HALT=4'hF;
  - the FSM state encoding: IDLE=1'b0, WAIT=1'b1;
  - the width constants: ADDR_W=8, INSN_W=8.
- **One sub-module, pc_reg:** the PC register with the load/increment/select logic. The fetch FSM and IR stay in fetch_unit.

## Test plan
- **Reset:** CLB low mid-cycle while in WAIT at PC=8'h10 → mem_req falls immediately, PC=8'h00, Opcode=0, Busy=0. A mem_valid arriving afterwards leaves IR at 8'h00.
- **Zero-wait fetch:** memory returns 8'h1A at 8'h00 on the cycle after req; pulse LoadIR → one cycle later Opcode=4'h1, Operand=4'hA, and Busy was high for exactly 1 cycle.
- **3-wait fetch:** mem_valid asserted 3 cycles after req → Busy high 4 cycles, mem_addr stable throughout, and a LoadIR pulse during WAIT causes no second request.
- **Wraparound:** PC=8'hFF with IncPC → PC=8'h00.
- **Priority and select:**
  - PC=8'h05, LoadPC=1, IncPC=1, SelPC=1, RegData=8'h42 → PC=8'h42.
  - With IR=8'h77, SelPC=0 → PC=8'h07.
- **Simultaneous events:** LoadIR and IncPC together at PC=8'h20 → mem_addr=8'h20 and PC=8'h21. The next fetch reads 8'h21.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the 8-bit micro:
// opcodes, widths and fetch FSM states.
package micro_pkg;

  localparam int ADDR_W = 8;
  localparam int INSN_W = 8;

  localparam logic [3:0] NOP   = 4'h0;
  localparam logic [3:0] ADD   = 4'h1;
  localparam logic [3:0] SUB   = 4'h2;
  localparam logic [3:0] NOR   = 4'h3;
  localparam logic [3:0] MOVRS = 4'h4;
  localparam logic [3:0] MOVRD = 4'h5;
  localparam logic [3:0] JZR   = 4'h6;
  localparam logic [3:0] JZI   = 4'h7;
  localparam logic [3:0] JCR   = 4'h8;
  localparam logic [3:0] SHL   = 4'hB;
  localparam logic [3:0] SHR   = 4'hC;
  localparam logic [3:0] LDI   = 4'hD;
  localparam logic [3:0] HALT  = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: jump load has priority
// over increment; increment wraps mod 256.
module pc_reg
  import micro_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic              sel,
  input  logic [ADDR_W-1:0] reg_data,
  input  logic [3:0]        operand,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] target;

  assign target = sel ? reg_data
                      : {{(ADDR_W-4){1'b0}}, operand};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR,
// fetches over a level req / valid handshake.
module fetch_unit
  import micro_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              LoadPC,
  input  logic              SelPC,
  input  logic [ADDR_W-1:0] RegData,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [3:0]        Opcode,
  output logic [3:0]        Operand,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy
);

  state_t            state;
  state_t            state_nxt;
  logic [INSN_W-1:0] ir;
  logic              start;
  logic              done;

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (LoadIR) state_nxt = WAIT;
      WAIT: if (mem_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == IDLE) && LoadIR;
    done  = (state == WAIT) && mem_valid;
  end

  // Address latches the pre-update PC.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      ir       <= '0;
      mem_addr <= '0;
    end else begin
      if (start) mem_addr <= PC;
      if (done)  ir       <= mem_rdata;
    end
  end

  assign Busy    = (state == WAIT);
  assign mem_req = Busy;
  assign Opcode  = ir[7:4];
  assign Operand = ir[3:0];

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (CLK),
    .rst_n   (CLB),
    .load    (LoadPC),
    .inc     (IncPC),
    .sel     (SelPC),
    .reg_data(RegData),
    .operand (ir[3:0]),
    .pc      (PC)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cases plus
// random traffic against a transaction model.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       CLB;
  logic       LoadIR, IncPC, LoadPC, SelPC;
  logic [7:0] RegData;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic [3:0] Opcode, Operand;
  logic [7:0] PC;
  logic       Busy;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // model: PC, IR, pending-fetch flag and its address
  int m_pc;
  int m_ir;
  bit m_busy;
  int m_addr;

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr];

  fetch_unit dut (
    .CLK      (CLK),
    .CLB      (CLB),
    .LoadIR   (LoadIR),
    .IncPC    (IncPC),
    .LoadPC   (LoadPC),
    .SelPC    (SelPC),
    .RegData  (RegData),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .Opcode   (Opcode),
    .Operand  (Operand),
    .PC       (PC),
    .Busy     (Busy)
  );

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_ir   = 0;
    m_busy = 1'b0;
    m_addr = 0;
  endtask

  task automatic model_edge();
    int nxt;
    if (!CLB) begin
      model_reset();
      return;
    end
    nxt = m_pc;
    if (LoadPC)
      nxt = SelPC ? int'(RegData) : (m_ir % 16);
    else if (IncPC)
      nxt = (m_pc + 1) % 256;
    if (m_busy) begin
      if (mem_valid) begin
        m_ir   = int'(mem[m_addr]);
        m_busy = 1'b0;
      end
    end else if (LoadIR) begin
      m_addr = m_pc;
      m_busy = 1'b1;
    end
    m_pc = nxt;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    LoadPC    = 1'b0;
    SelPC     = 1'b0;
    RegData   = 8'h00;
    mem_valid = 1'b0;
  endtask

  task automatic set_pc(input logic [7:0] v);
    LoadPC  = 1'b1;
    SelPC   = 1'b1;
    RegData = v;
    step();
    idle_in();
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc", int'(PC), m_pc);
      chk("opcode", int'(Opcode), m_ir / 16);
      chk("operand", int'(Operand), m_ir % 16);
      chk("busy", int'(Busy), int'(m_busy));
      chk("mem_req", int'(mem_req), int'(m_busy));
      chk("mem_addr", int'(mem_addr), m_addr);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 8'($urandom);
    idle_in();
    CLB = 1'b0;
    model_reset();
    chk_en = 1'b1;
    step();
    step();
    CLB = 1'b1;
    chk("rst_pc", int'(PC), 8'h00);
    chk("rst_op", int'(Opcode), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_req", int'(mem_req), 0);
    chk("rst_addr", int'(mem_addr), 0);

    // zero-wait fetch
    mem[0] = 8'h1A;
    LoadIR = 1'b1;
    step();
    LoadIR = 1'b0;
    chk("zw_busy1", int'(Busy), 1);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("zw_busy0", int'(Busy), 0);
    chk("zw_opc", int'(Opcode), 4'h1);
    chk("zw_opr", int'(Operand), 4'hA);

    // three wait cycles, stray LoadIR in WAIT
    mem[0] = 8'h3C;
    LoadIR = 1'b1;
    step();
    LoadIR = 1'b0;
    chk("w3_busy", int'(Busy), 1);
    for (int i = 0; i < 3; i++) begin
      LoadIR = (i == 1);
      step();
      LoadIR = 1'b0;
      chk("w3_busy", int'(Busy), 1);
      chk("w3_addr", int'(mem_addr), 0);
    end
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("w3_done", int'(Busy), 0);
    chk("w3_opc", int'(Opcode), 4'h3);
    chk("w3_opr", int'(Operand), 4'hC);
    step();
    chk("w3_no2nd", int'(mem_req), 0);

    // wraparound
    set_pc(8'hFF);
    chk("wrap_ff", int'(PC), 8'hFF);
    IncPC = 1'b1;
    step();
    IncPC = 1'b0;
    chk("wrap_00", int'(PC), 8'h00);

    // priority and select
    set_pc(8'h05);
    LoadPC  = 1'b1;
    IncPC   = 1'b1;
    SelPC   = 1'b1;
    RegData = 8'h42;
    step();
    idle_in();
    chk("prio", int'(PC), 8'h42);
    mem[8'h42] = 8'h77;
    LoadIR = 1'b1;
    step();
    LoadIR    = 1'b0;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("ir77", int'(Opcode), 4'h7);
    LoadPC = 1'b1;
    step();
    LoadPC = 1'b0;
    chk("sel_opr", int'(PC), 8'h07);

    // fetch and increment together
    set_pc(8'h20);
    mem[8'h20] = 8'h55;
    mem[8'h21] = 8'h66;
    LoadIR = 1'b1;
    IncPC  = 1'b1;
    step();
    idle_in();
    chk("sim_addr", int'(mem_addr), 8'h20);
    chk("sim_pc", int'(PC), 8'h21);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("sim_ir", int'(Opcode), 4'h5);
    LoadIR = 1'b1;
    step();
    LoadIR = 1'b0;
    chk("sim_addr2", int'(mem_addr), 8'h21);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("sim_ir2", int'(Opcode), 4'h6);

    // async reset while waiting
    set_pc(8'h10);
    LoadIR = 1'b1;
    step();
    LoadIR = 1'b0;
    chk("rw_busy", int'(Busy), 1);
    #2;
    CLB = 1'b0;
    model_reset();
    #1;
    chk("rw_req", int'(mem_req), 0);
    chk("rw_pc", int'(PC), 8'h00);
    chk("rw_opc", int'(Opcode), 0);
    chk("rw_busy0", int'(Busy), 0);
    mem_valid = 1'b1;
    step();
    CLB = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("rw_ir", int'(Opcode), 0);
    chk("rw_idle", int'(Busy), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      LoadIR    = ($urandom_range(1) == 1);
      IncPC     = ($urandom_range(1) == 1);
      LoadPC    = ($urandom_range(7) == 0);
      SelPC     = ($urandom_range(1) == 1);
      RegData   = 8'($urandom);
      mem_valid = ($urandom_range(2) == 0);
      step();
    end
    idle_in();
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
